// File: rtl/fetch_buf_ctrl.sv
// Instruction fetch buffer controller: a circular {pc, inst} queue that takes up to two
// instructions per cycle from fetch and issues up to two per cycle toward decode.
module fetch_buf_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              stall,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [1:0]        if_cnt,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_inst0,
  input  logic [31:0]       if_inst1,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [1:0]        id_cnt,
  output logic [31:0]       id_inst0,
  output logic [31:0]       id_inst1,
  output logic [31:0]       id_pc0,
  output logic [31:0]       id_pc1,
  output logic              buf_empty,
  output logic              buf_full,
  output logic [PTR_W:0]    buf_count
);

  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  localparam int unsigned CNT_W    = PTR_W + 1;

  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_inst_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [1:0]       push_n, pop_n, avail;

  // Pointers are PTR_W bits wide, so +1 / +2 wrap modulo DEPTH for free.
  assign head_nxt = head_q + PTR_W'(1);
  assign tail_nxt = tail_q + PTR_W'(1);

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == CNT_W'(DEPTH));
  assign buf_count = count_q;

  // Room for a two-wide push is required even when only one instruction arrives.
  assign if_ready = !flush && (count_q <= CNT_W'(DEPTH - 2));
  assign push     = if_valid && if_ready && ((if_cnt == 2'd1) || (if_cnt == 2'd2));
  assign push_n   = push ? if_cnt : 2'd0;

  assign avail    = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
  assign id_cnt   = (!flush && !stall) ? avail : 2'd0;
  assign id_valid = (id_cnt != 2'd0);
  assign pop      = id_valid && id_ready;
  assign pop_n    = pop ? id_cnt : 2'd0;

  // Show-ahead view of head and head+1; empty slots read as NOP at pc 0.
  always_comb begin
    id_inst0 = INST_NOP;
    id_pc0   = 32'd0;
    id_inst1 = INST_NOP;
    id_pc1   = 32'd0;
    if (!buf_empty) begin
      id_inst0 = mem_inst_q[head_q];
      id_pc0   = mem_pc_q[head_q];
    end
    if (id_cnt == 2'd2) begin
      id_inst1 = mem_inst_q[head_nxt];
      id_pc1   = mem_pc_q[head_nxt];
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[tail_q]   <= if_pc;
      mem_inst_q[tail_q] <= if_inst0;
      if (if_cnt == 2'd2) begin
        mem_pc_q[tail_nxt]   <= if_pc + 32'd4;
        mem_inst_q[tail_nxt] <= if_inst1;
      end
    end
  end

endmodule
